image_frame_loader: RTL and testbench
=====================================

# image_frame_loader

Upstream feeder for the `inference` block. Receives framed 784-pixel MNIST images from the UART byte stream and stores them in a two-bank ping-pong image buffer, so the next image loads while the current one is classified. Serves `input_pixel` to `inference` through its `input_addr` read port. Issues `start_inference` for each complete, valid frame once weights are loaded and `inference` is idle.

## Interface
Parameters:
- `NUM_PIXELS`, 784, pixels per frame.
- `ADDR_W`, 10, pixel address width.
- `START_BYTE`, 8'hAA, frame header byte.
- `END_BYTE`, 8'h55, frame trailer byte.
- `TIMEOUT_CYCLES`, 1_000_000, maximum idle clocks between bytes inside a frame.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `rx_data` in 8: received UART byte.
- `rx_valid` in 1: one-cycle strobe; `rx_data` is valid this cycle.
- `weights_ready` in 1: weight and bias memories are loaded.
- `inference_busy` in 1: `busy` from `inference`.
- `inference_done` in 1: `inference_done` from `inference`; one-cycle pulse.
- `input_addr` in ADDR_W: pixel address from `inference`.
- `input_pixel` out 8: pixel at `input_addr` in the read bank; registered.
- `start_inference` out 1: one-cycle launch pulse.
- `loading` out 1: a frame is being received.
- `frames_pending` out 2: count of FULL banks, 0..2.
- `frame_error` out 1: one-cycle pulse on bad trailer or timeout.
- `overrun` out 1: one-cycle pulse when START_BYTE is dropped because no bank is free.

## Operation
Bank states (one per bank, two banks):
- EMPTY -> FILLING when a frame starts into the bank.
- FILLING -> FULL on a correct trailer.
- FILLING -> EMPTY on error.
- FULL -> READING on launch.
- READING -> EMPTY on `inference_done`.
- An `older` bit records which FULL bank arrived first. Launch always takes the oldest FULL bank.

Receive FSM:
- RX_IDLE:
  - START_BYTE with an EMPTY bank present: lowest-index EMPTY bank becomes FILLING, `pix_cnt`=0, go RX_LOAD.
  - START_BYTE with no EMPTY bank: pulse `overrun`, stay.
  - Any other byte: ignored.
- RX_LOAD: each byte is written to `mem[bank][pix_cnt]` and `pix_cnt` increments. The byte written at `pix_cnt`=783 moves the FSM to RX_END. Byte values are not interpreted, so 0xAA and 0x55 are legal pixels.
- RX_END:
  - END_BYTE: bank becomes FULL, go RX_IDLE.
  - Any other byte: pulse `frame_error`, bank becomes EMPTY, go RX_IDLE.
- Timeout: in RX_LOAD or RX_END, `TIMEOUT_CYCLES` consecutive clocks without `rx_valid` cause `frame_error`, the bank becomes EMPTY, and the FSM goes to RX_IDLE. The timeout counter clears on every `rx_valid`.

Launch FSM:
- L_IDLE: when a FULL bank exists, `weights_ready`=1 and `inference_busy`=0:
  - `read_bank` is set to the oldest FULL bank;
  - that bank becomes READING;
  - `start_inference` pulses;
  - go L_RUN.
- L_RUN: on `inference_done`, the READING bank becomes EMPTY and the FSM goes to L_IDLE.
- `inference_done` seen in L_IDLE is ignored.

Read port:
- `input_pixel` <= `mem[read_bank][input_addr]` every clock.
- `input_addr` >= NUM_PIXELS returns 0.

## Timing
- Reset: all banks EMPTY, both FSMs idle, all counters 0, `read_bank`=0. Every output is 0.
- Reset asserted mid-frame or mid-inference discards all frames. No `start_inference` may appear until a new full frame completes.
- Read latency is 1 clock from `input_addr` to `input_pixel`.
- Trailer to launch: trailer accepted on cycle T -> bank FULL at T+1 -> `start_inference` high on T+1, provided the launch conditions hold at T+1.
- `frames_pending` updates on the clock edge after any bank state change.
- Simultaneous `inference_done` and trailer on cycle T:
  - the READING bank becomes EMPTY;
  - the new bank becomes FULL;
  - the next launch fires no earlier than T+1, and only if `inference_busy`=0.
- Simultaneous `inference_done` and START_BYTE in RX_IDLE with no EMPTY bank: the START_BYTE is dropped with `overrun`. The freed bank counts only from the next cycle.
- `start_inference` is never asserted on consecutive cycles. At most one inference is outstanding at a time.

## Structure
- Shared package `mnist_pkg`:
  - constants `NUM_PIXELS`, `PIX_ADDR_W`, `FRAME_START`, `FRAME_END`;
  - `bank_state_t` enum: EMPTY, FILLING, FULL, READING.
- Sub-module `image_bank_ram`:
  - 2×784×8 storage;
  - one synchronous write port (bank, addr, data, we);
  - one registered read port (bank, addr);
  - must map to a single BRAM.
- FSMs, counters and bank bookkeeping live in `image_frame_loader`.

## Test plan
- Happy path: `weights_ready`=1, send 0xAA, 784 bytes of value i%256, then 0x55. Required: `start_inference` one cycle after the trailer, `frames_pending` 1 -> 0, and `input_addr`=300 returns 0x2C one clock later.
- Bad trailer: send a frame ending in 0x56. Required: `frame_error` pulse, no `start_inference`, `frames_pending`=0.
- Ping-pong with the bench holding `inference_busy`=1:
  - Send 3 frames. Required: frames 1 and 2 stored (`frames_pending`=2); frame 3's START_BYTE gives `overrun`.
  - Release busy and pulse `inference_done` twice. Required: frames launched in order 1, 2, confirmed by reading pixel 0.
- Timeout: stop after 100 pixels and wait `TIMEOUT_CYCLES` (bench override 50). Required: `frame_error`; a following full frame launches normally.
- Weights gating: full frame received with `weights_ready`=0. Required: no launch. Raise `weights_ready` -> `start_inference` on the next cycle.
- Reset during RX_LOAD and during L_RUN: all outputs 0. Required: no launch until a new frame completes.

Source files
------------

// File: rtl/mnist_pkg.sv
// mnist_pkg: constants and types shared by the MNIST front-end blocks.
//   NUM_PIXELS / PIX_ADDR_W : frame geometry (28x28 pixels, 10-bit address)
//   FRAME_START / FRAME_END : frame header and trailer bytes
//   bank_state_t            : life cycle of one image buffer bank
//   rx_state_t              : receive FSM states
//   launch_state_t          : launch FSM states
//   count_full()            : number of banks holding a complete, unread frame
package mnist_pkg;

  localparam int         NUM_PIXELS  = 784;
  localparam int         PIX_ADDR_W  = 10;
  localparam logic [7:0] FRAME_START = 8'hAA;
  localparam logic [7:0] FRAME_END   = 8'h55;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2,
    READING = 2'd3
  } bank_state_t;

  typedef enum logic [1:0] {
    RX_IDLE = 2'd0,
    RX_LOAD = 2'd1,
    RX_END  = 2'd2
  } rx_state_t;

  typedef enum logic {
    L_IDLE = 1'b0,
    L_RUN  = 1'b1
  } launch_state_t;

  function automatic logic [1:0] count_full(input bank_state_t b0, input bank_state_t b1);
    return {1'b0, b0 == FULL} + {1'b0, b1 == FULL};
  endfunction

endpackage

// File: rtl/image_bank_ram.sv
// image_bank_ram: two-bank image store, 2 x NUM_PIXELS x 8 bits in one array.
//   clk, rst          : clock, asynchronous active-low reset (read register only)
//   we, wr_bank,
//   wr_addr, wr_data  : synchronous write port
//   rd_bank, rd_addr  : read address, sampled every clock
//   rd_clear          : forces the next read result to zero (out-of-range address)
//   rd_data           : registered read data, one clock after the address
module image_bank_ram #(
  parameter int NUM_PIXELS = 784,
  parameter int ADDR_W     = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              wr_bank,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic              rd_bank,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_clear,
  output logic [7:0]        rd_data
);

  localparam int DEPTH = 2 * NUM_PIXELS;
  localparam int AW    = $clog2(DEPTH);

  logic [7:0]    mem_r [DEPTH];
  logic [AW-1:0] wr_idx_s;
  logic [AW-1:0] rd_idx_s;

  // Bank 1 sits directly above bank 0, so the array is packed with no holes.
  always_comb begin
    wr_idx_s = wr_bank ? (AW'(NUM_PIXELS) + AW'(wr_addr)) : AW'(wr_addr);
    rd_idx_s = rd_bank ? (AW'(NUM_PIXELS) + AW'(rd_addr)) : AW'(rd_addr);
  end

  // Write port: storage array has no reset so it stays a plain memory.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[wr_idx_s] <= wr_data;
    end
  end

  // Read port: output register, cleared for addresses past the frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data <= 8'd0;
    end else if (rd_clear) begin
      rd_data <= 8'd0;
    end else begin
      rd_data <= mem_r[rd_idx_s];
    end
  end

endmodule

// File: rtl/image_frame_loader.sv
// image_frame_loader: receives framed images from the UART byte stream into a
// ping-pong buffer and launches the inference block on each complete frame.
//   clk, rst        : clock, asynchronous active-low reset
//   rx_data/valid   : received byte and its one-cycle strobe
//   weights_ready   : weight memories loaded; launches are held off until set
//   inference_busy  : inference block is running
//   inference_done  : one-cycle completion pulse from the inference block
//   input_addr      : pixel address from the inference block
//   input_pixel     : pixel from the bank being read, one clock after input_addr
//   start_inference : one-cycle launch pulse
//   loading         : a frame is being received
//   frames_pending  : number of FULL banks (0..2)
//   frame_error     : one-cycle pulse on bad trailer or inter-byte timeout
//   overrun         : one-cycle pulse when a header is dropped for lack of a bank
module image_frame_loader #(
  parameter int         NUM_PIXELS     = mnist_pkg::NUM_PIXELS,
  parameter int         ADDR_W         = mnist_pkg::PIX_ADDR_W,
  parameter logic [7:0] START_BYTE     = mnist_pkg::FRAME_START,
  parameter logic [7:0] END_BYTE       = mnist_pkg::FRAME_END,
  parameter int         TIMEOUT_CYCLES = 1_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              weights_ready,
  input  logic              inference_busy,
  input  logic              inference_done,
  input  logic [ADDR_W-1:0] input_addr,
  output logic [7:0]        input_pixel,
  output logic              start_inference,
  output logic              loading,
  output logic [1:0]        frames_pending,
  output logic              frame_error,
  output logic              overrun
);

  import mnist_pkg::*;

  localparam int                TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(NUM_PIXELS - 1);
  localparam logic [TW-1:0]     TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  bank_state_t       bank_r [2];
  logic              older_r;      // which bank became FULL first when both are FULL
  rx_state_t         rx_state_r;
  launch_state_t     l_state_r;
  logic              fill_bank_r;
  logic              read_bank_r;
  logic [ADDR_W-1:0] pix_cnt_r;
  logic [TW-1:0]     idle_cnt_r;

  logic [1:0] is_empty_s;
  logic [1:0] is_full_s;
  logic       empty_idx_s;
  logic       oldest_full_s;
  logic       launch_s;
  logic       byte_start_s;
  logic       timeout_s;
  logic       we_s;
  logic       addr_oob_s;

  // Bank lookups and event qualifiers, all taken from the current registered state.
  always_comb begin
    is_empty_s    = {bank_r[1] == EMPTY, bank_r[0] == EMPTY};
    is_full_s     = {bank_r[1] == FULL,  bank_r[0] == FULL};
    empty_idx_s   = ~is_empty_s[0];
    oldest_full_s = (&is_full_s) ? older_r : is_full_s[1];
    launch_s      = (l_state_r == L_IDLE) && (|is_full_s) && weights_ready && !inference_busy;
    byte_start_s  = (rx_state_r == RX_IDLE) && rx_valid && (rx_data == START_BYTE);
    timeout_s     = (rx_state_r != RX_IDLE) && !rx_valid && (idle_cnt_r == TO_LAST);
    we_s          = (rx_state_r == RX_LOAD) && rx_valid;
    addr_oob_s    = input_addr >= ADDR_W'(NUM_PIXELS);
  end

  // Receive FSM, launch FSM and bank bookkeeping. The two FSMs only ever
  // touch banks in different states, so their bank updates never collide.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bank_r[0]       <= EMPTY;
      bank_r[1]       <= EMPTY;
      older_r         <= 1'b0;
      rx_state_r      <= RX_IDLE;
      l_state_r       <= L_IDLE;
      fill_bank_r     <= 1'b0;
      read_bank_r     <= 1'b0;
      pix_cnt_r       <= '0;
      idle_cnt_r      <= '0;
      start_inference <= 1'b0;
      loading         <= 1'b0;
      frames_pending  <= 2'd0;
      frame_error     <= 1'b0;
      overrun         <= 1'b0;
    end else begin
      start_inference <= 1'b0;
      frame_error     <= 1'b0;
      overrun         <= 1'b0;
      frames_pending  <= count_full(bank_r[0], bank_r[1]);

      case (rx_state_r)
        RX_IDLE: begin
          if (byte_start_s && (|is_empty_s)) begin
            bank_r[empty_idx_s] <= FILLING;
            fill_bank_r         <= empty_idx_s;
            pix_cnt_r           <= '0;
            idle_cnt_r          <= '0;
            loading             <= 1'b1;
            rx_state_r          <= RX_LOAD;
          end else if (byte_start_s) begin
            overrun <= 1'b1;
          end
        end
        RX_LOAD: begin
          if (rx_valid) begin
            idle_cnt_r <= '0;
            pix_cnt_r  <= pix_cnt_r + ADDR_W'(1);
            if (pix_cnt_r == LAST_PIX) begin
              rx_state_r <= RX_END;
            end
          end else if (timeout_s) begin
            bank_r[fill_bank_r] <= EMPTY;
            frame_error         <= 1'b1;
            loading             <= 1'b0;
            rx_state_r          <= RX_IDLE;
          end else begin
            idle_cnt_r <= idle_cnt_r + TW'(1);
          end
        end
        RX_END: begin
          if (rx_valid) begin
            idle_cnt_r <= '0;
            loading    <= 1'b0;
            rx_state_r <= RX_IDLE;
            if (rx_data == END_BYTE) begin
              bank_r[fill_bank_r] <= FULL;
              // Only claim "oldest" when the other bank holds no waiting frame.
              if (!is_full_s[~fill_bank_r]) begin
                older_r <= fill_bank_r;
              end
            end else begin
              bank_r[fill_bank_r] <= EMPTY;
              frame_error         <= 1'b1;
            end
          end else if (timeout_s) begin
            bank_r[fill_bank_r] <= EMPTY;
            frame_error         <= 1'b1;
            loading             <= 1'b0;
            rx_state_r          <= RX_IDLE;
          end else begin
            idle_cnt_r <= idle_cnt_r + TW'(1);
          end
        end
        default: begin
          rx_state_r <= RX_IDLE;
        end
      endcase

      case (l_state_r)
        L_IDLE: begin
          if (launch_s) begin
            bank_r[oldest_full_s] <= READING;
            read_bank_r           <= oldest_full_s;
            start_inference       <= 1'b1;
            l_state_r             <= L_RUN;
          end
        end
        L_RUN: begin
          if (inference_done) begin
            bank_r[read_bank_r] <= EMPTY;
            l_state_r           <= L_IDLE;
          end
        end
        default: begin
          l_state_r <= L_IDLE;
        end
      endcase
    end
  end

  image_bank_ram #(
    .NUM_PIXELS (NUM_PIXELS),
    .ADDR_W     (ADDR_W)
  ) u_ram (
    .clk      (clk),
    .rst      (rst),
    .we       (we_s),
    .wr_bank  (fill_bank_r),
    .wr_addr  (pix_cnt_r),
    .wr_data  (rx_data),
    .rd_bank  (read_bank_r),
    .rd_addr  (input_addr),
    .rd_clear (addr_oob_s),
    .rd_data  (input_pixel)
  );

endmodule

// File: tb/tb_image_frame_loader.sv
// tb_image_frame_loader: directed bench for image_frame_loader. Frames carry
// pixel i = (seed + i) % 256; each frame expected to launch pushes its seed to
// a queue, and every launch pops it and checks pixels read back from the DUT.
module tb_image_frame_loader;

  localparam int NP = 784;
  localparam int AW = 10;
  localparam int TO = 50;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [7:0]    rx_data = 8'd0;
  logic          rx_valid = 1'b0;
  logic          weights_ready = 1'b0;
  logic          inference_busy = 1'b0;
  logic          inference_done = 1'b0;
  logic [AW-1:0] input_addr = '0;
  logic [7:0]    input_pixel;
  logic          start_inference;
  logic          loading;
  logic [1:0]    frames_pending;
  logic          frame_error;
  logic          overrun;

  int errors = 0;
  int checks = 0;
  int starts = 0;
  int starts0 = 0;
  int exp_q[$];
  logic prev_start = 1'b0;

  image_frame_loader #(.TIMEOUT_CYCLES(TO)) dut (
    .clk             (clk),
    .rst             (rst),
    .rx_data         (rx_data),
    .rx_valid        (rx_valid),
    .weights_ready   (weights_ready),
    .inference_busy  (inference_busy),
    .inference_done  (inference_done),
    .input_addr      (input_addr),
    .input_pixel     (input_pixel),
    .start_inference (start_inference),
    .loading         (loading),
    .frames_pending  (frames_pending),
    .frame_error     (frame_error),
    .overrun         (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pix(input int seed, input int i);
    return 8'((seed + i) % 256);
  endfunction

  // Launch monitor on the falling edge: counts pulses, rejects back-to-back ones.
  always @(negedge clk) begin
    if (start_inference === 1'b1) begin
      starts <= starts + 1;
      check("start_back_to_back", {31'd0, prev_start}, 32'd0);
    end
    prev_start <= start_inference;
  end

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick(1);
    rx_valid = 1'b0;
  endtask

  // Header, npix pixels, and the trailer only when the frame is complete.
  task automatic send_frame(input int seed, input logic [7:0] trailer, input int npix);
    send_byte(8'hAA);
    for (int i = 0; i < npix; i++) send_byte(pix(seed, i));
    if (npix == NP) send_byte(trailer);
  endtask

  // Called just after a launch pulse is seen: act busy, pop the expected frame
  // and compare pixels 0 and 300 of the bank being read.
  task automatic consume_launch(input string tag);
    int seed;
    inference_busy = 1'b1;
    check({tag, "_expected_frame"}, {31'd0, exp_q.size() > 0}, 32'd1);
    seed = (exp_q.size() > 0) ? exp_q.pop_front() : 0;
    input_addr = 10'd0;
    tick(1);
    check({tag, "_pixel0"}, {24'd0, input_pixel}, {24'd0, pix(seed, 0)});
    input_addr = 10'd300;
    tick(1);
    check({tag, "_pixel300"}, {24'd0, input_pixel}, {24'd0, pix(seed, 300)});
  endtask

  task automatic finish_inference();
    inference_done = 1'b1;
    inference_busy = 1'b0;
    tick(1);
    inference_done = 1'b0;
  endtask

  task automatic wait_start(input string tag, input int budget);
    int n = 0;
    while (start_inference !== 1'b1 && n < budget) begin
      tick(1);
      n++;
    end
    check({tag, "_start_seen"}, {31'd0, start_inference}, 32'd1);
    if (start_inference === 1'b1) consume_launch(tag);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_start"},       {31'd0, start_inference}, 32'd0);
    check({tag, "_loading"},     {31'd0, loading},         32'd0);
    check({tag, "_pending"},     {30'd0, frames_pending},  32'd0);
    check({tag, "_frame_error"}, {31'd0, frame_error},     32'd0);
    check({tag, "_overrun"},     {31'd0, overrun},         32'd0);
    check({tag, "_pixel"},       {24'd0, input_pixel},     32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Reset state.
    tick(5);
    check_all_zero("reset");
    rst = 1'b1;
    tick(2);

    // Happy path: launch exactly one cycle after the trailer edge.
    weights_ready = 1'b1;
    exp_q.push_back(0);
    send_frame(0, 8'h55, NP);
    check("happy_loading_off", {31'd0, loading}, 32'd0);
    tick(1);
    check("happy_start", {31'd0, start_inference}, 32'd1);
    check("happy_pending1", {30'd0, frames_pending}, 32'd1);
    consume_launch("happy");
    check("happy_pending0", {30'd0, frames_pending}, 32'd0);
    input_addr = 10'd170;
    tick(1);
    check("happy_pixel_aa", {24'd0, input_pixel}, 32'h0000_00AA);
    input_addr = 10'd85;
    tick(1);
    check("happy_pixel_55", {24'd0, input_pixel}, 32'h0000_0055);
    input_addr = 10'd783;
    tick(1);
    check("happy_pixel783", {24'd0, input_pixel}, 32'h0000_000F);
    input_addr = 10'd784;
    tick(1);
    check("happy_addr_oob", {24'd0, input_pixel}, 32'd0);
    finish_inference();

    // Bad trailer.
    starts0 = starts;
    send_frame(7, 8'h56, NP);
    check("bad_trailer_error", {31'd0, frame_error}, 32'd1);
    tick(3);
    check("bad_trailer_error_pulse", {31'd0, frame_error}, 32'd0);
    check("bad_trailer_pending", {30'd0, frames_pending}, 32'd0);
    check("bad_trailer_no_start", starts, starts0);

    // Ping-pong with the consumer held busy.
    inference_busy = 1'b1;
    exp_q.push_back(1);
    send_frame(1, 8'h55, NP);
    exp_q.push_back(2);
    send_frame(2, 8'h55, NP);
    tick(2);
    check("pingpong_pending2", {30'd0, frames_pending}, 32'd2);
    send_byte(8'hAA);
    check("pingpong_overrun", {31'd0, overrun}, 32'd1);
    check("pingpong_no_load", {31'd0, loading}, 32'd0);
    tick(1);
    check("pingpong_overrun_pulse", {31'd0, overrun}, 32'd0);
    inference_busy = 1'b0;
    wait_start("pingpong_first", 4);
    finish_inference();
    wait_start("pingpong_second", 4);
    finish_inference();
    tick(2);
    check("pingpong_drained", {30'd0, frames_pending}, 32'd0);

    // Timeout after 100 pixels, then a normal frame.
    send_frame(9, 8'h55, 100);
    check("timeout_loading", {31'd0, loading}, 32'd1);
    n = 0;
    while (frame_error !== 1'b1 && n < TO + 10) begin
      tick(1);
      n++;
    end
    check("timeout_cycles", n, TO);
    check("timeout_loading_off", {31'd0, loading}, 32'd0);
    exp_q.push_back(3);
    send_frame(3, 8'h55, NP);
    wait_start("after_timeout", 3);
    finish_inference();

    // Weights gating.
    weights_ready = 1'b0;
    starts0 = starts;
    exp_q.push_back(4);
    send_frame(4, 8'h55, NP);
    tick(5);
    check("gating_no_start", starts, starts0);
    check("gating_pending", {30'd0, frames_pending}, 32'd1);
    weights_ready = 1'b1;
    tick(1);
    check("gating_start_next", {31'd0, start_inference}, 32'd1);
    consume_launch("gating");
    finish_inference();

    // Reset in the middle of a frame.
    send_frame(5, 8'h55, 50);
    rst = 1'b0;
    tick(2);
    check_all_zero("reset_rx_load");
    rst = 1'b1;
    starts0 = starts;
    tick(10);
    check("reset_rx_load_no_start", starts, starts0);

    // Reset in the middle of an inference.
    exp_q.push_back(6);
    send_frame(6, 8'h55, NP);
    wait_start("pre_reset_run", 3);
    rst = 1'b0;
    inference_busy = 1'b0;
    tick(2);
    check_all_zero("reset_l_run");
    rst = 1'b1;
    starts0 = starts;
    tick(10);
    check("reset_l_run_no_start", starts, starts0);
    exp_q.push_back(8);
    send_frame(8, 8'h55, NP);
    wait_start("after_reset", 3);
    finish_inference();
    tick(2);
    check("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
